spi_cmd_regfile: RTL

- Byte-level command engine directly downstream of the SPI slave shifter, in the sclk domain.
- Consumes each received byte (sendrecv pulse + buffer_in) and decodes a command/address byte followed by streamed data bytes.
- Owns a small register file and drives outbuf, the byte the shifter loads at each byte boundary for transmission on miso.
- Exposes register contents and a write strobe to the rest of the design.

---
 rtl/spi_cmd_regfile.sv | 111 +++++++++++
 1 files changed

// File: rtl/spi_cmd_regfile.sv
// Byte-level SPI command engine: decodes a cmd/address byte, then streams register writes or reads.
// Build option: define SPI_AUTOINC_EN to advance the address after every data byte.
`timescale 1ns/1ps

module spi_cmd_regfile #(
    parameter int         NUM_REGS  = 16,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic                  sclk,
    input  logic                  rst_L,
    input  logic                  ss,
    input  logic                  sendrecv,
    input  logic [7:0]            buffer_in,
    output logic [7:0]            outbuf,
    input  logic [7:0]            status_in,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic                  wr_stb,
    output logic [6:0]            wr_addr,
    output logic                  busy
);

    // state | meaning
    // IDLE  | waiting for a command byte
    // WR    | each received byte is written to reg[addr]
    // RD    | each received byte advances the read pointer and reloads outbuf
    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t     state;
    logic [6:0] addr;
    logic [6:0] addr_nxt;
    logic [7:0] reg_q [1:NUM_REGS-1];
    logic [7:0] rd_cmd;
    logic [7:0] rd_nxt;
    logic       wr_hit;

`ifdef SPI_AUTOINC_EN
    assign addr_nxt = addr + 7'd1;
`else
    assign addr_nxt = addr;
`endif

    // Slot 0 is never stored; it always reflects the live status byte.
    always_comb begin
        rd_cmd = 8'hFF;
        rd_nxt = 8'hFF;
        wr_hit = 1'b0;
        if (buffer_in[6:0] == 7'd0) rd_cmd = status_in;
        if (addr_nxt == 7'd0)       rd_nxt = status_in;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (buffer_in[6:0] == 7'(i)) rd_cmd = reg_q[i];
            if (addr_nxt == 7'(i))       rd_nxt = reg_q[i];
            if (addr == 7'(i))           wr_hit = 1'b1;
        end
    end

    always_ff @(posedge sclk or negedge rst_L) begin
        if (!rst_L) begin
            state   <= IDLE;
            addr    <= 7'd0;
            outbuf  <= 8'h00;
            wr_stb  <= 1'b0;
            wr_addr <= 7'd0;
            busy    <= 1'b0;
            for (int i = 1; i < NUM_REGS; i++) reg_q[i] <= RESET_VAL;
        end else begin
            wr_stb <= 1'b0;
            if (sendrecv) begin
                case (state)
                    IDLE: begin
                        if (!ss) begin
                            addr <= buffer_in[6:0];
                            busy <= 1'b1;
                            if (buffer_in[7]) begin
                                state <= WR;
                            end else begin
                                state  <= RD;
                                outbuf <= rd_cmd;
                            end
                        end
                    end
                    WR: begin
                        if (wr_hit) begin
                            for (int i = 1; i < NUM_REGS; i++)
                                if (addr == 7'(i)) reg_q[i] <= buffer_in;
                            wr_stb  <= 1'b1;
                            wr_addr <= addr;
                        end
                        addr <= addr_nxt;
                    end
                    RD: begin
                        addr   <= addr_nxt;
                        outbuf <= rd_nxt;
                    end
                    default: state <= IDLE;
                endcase
            end
            // Deselect wins over the byte just handled, but that byte has already committed.
            if (ss) begin
                state  <= IDLE;
                busy   <= 1'b0;
                outbuf <= 8'h00;
            end
        end
    end

    assign regs_flat[7:0] = status_in;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = reg_q[g];
    end

endmodule
